// File: rtl/hpm_pkg.sv
// Shared definitions for the hardware performance-monitor counter bank:
// CSR op encoding, CSR address map and EVSEL field positions.
package hpm_pkg;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [11:0] CNT_LO_BASE  = 12'hB03;
  localparam logic [11:0] CNT_HI_BASE  = 12'hB83;
  localparam logic [11:0] EVSEL_BASE   = 12'h323;
  localparam logic [11:0] INHIBIT_ADDR = 12'h320;
  localparam logic [11:0] OVF_ADDR     = 12'h7C0;

  localparam int unsigned EV_IDX_LSB = 0;
  localparam int unsigned EV_IDX_MSB = 7;
  localparam int unsigned SAT_BIT    = 30;
  localparam int unsigned IRQ_EN_BIT = 31;

  // Read-modify-write result of a CSR op applied to the current readable value.
  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] r,
                                            input logic [31:0] w);
    logic [31:0] res;
    case (op)
      CSR_WRITE: res = w;
      CSR_SET:   res = r | w;
      CSR_CLEAR: res = r & ~w;
      default:   res = r;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One performance counter slice: CNT_W-bit register with increment,
// wrap/saturate on overflow, 32-bit lo/hi write merge and an overflow pulse.
module hpm_counter #(
  parameter int unsigned CNT_W = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        sat_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rd_lo_o,
  output logic [31:0] rd_hi_o,
  output logic        ovf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [63:0]      cnt64;

  // Zero-extended view lets lo/hi merges work for any width; bits at or above
  // CNT_W are dropped by the truncating cast, so CNT_HI writes vanish when CNT_W<=32.
  assign cnt64   = 64'(cnt_q);
  assign rd_lo_o = cnt64[31:0];
  assign rd_hi_o = cnt64[63:32];

  // Next value: a CSR write takes priority and swallows a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (wr_lo_i) begin
      cnt_d = CNT_W'({cnt64[63:32], wdata_i});
    end else if (wr_hi_i) begin
      cnt_d = CNT_W'({wdata_i, cnt64[31:0]});
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_o = 1'b1;
        cnt_d = sat_i ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hpm_counter_bank.sv
// Programmable performance-monitor bank on the CSR bus: address decode,
// read mux, registered events, per-counter selectors, INHIBIT/OVF and irq.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int unsigned N_CNT = 4,
  parameter int unsigned CNT_W = 48,
  parameter int unsigned N_EVT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             csr_access_i,
  input  logic [11:0]      csr_addr_i,
  input  logic [31:0]      csr_wdata_i,
  input  logic [1:0]       csr_op_i,
  output logic [31:0]      csr_rdata_o,
  output logic             csr_hit_o,
  input  logic [N_EVT-1:0] events_i,
  input  logic             freeze_i,
  output logic             ovf_irq_o
);

  logic [N_EVT-1:0] events_q;
  logic [255:0]     evt_ext;
  logic [7:0]       ev_idx_q [N_CNT];
  logic [N_CNT-1:0] sat_q;
  logic [N_CNT-1:0] irq_en_q;
  logic [N_CNT-1:0] inhibit_q;
  logic [N_CNT-1:0] ovf_q;
  logic [N_CNT-1:0] inc;
  logic [N_CNT-1:0] ovf_pulse;
  logic [N_CNT-1:0] lo_sel;
  logic [N_CNT-1:0] hi_sel;
  logic [N_CNT-1:0] ev_sel;
  logic             inh_sel;
  logic             ovf_sel;
  logic             any_hit;
  logic             we;
  logic             irq_q;
  logic [31:0]      r_val;
  logic [31:0]      new_val;
  logic [31:0]      rd_lo [N_CNT];
  logic [31:0]      rd_hi [N_CNT];

  // Index 0 maps to a constant 0 and indices above N_EVT land in zero padding.
  assign evt_ext = 256'({events_q, 1'b0});

  // Address decode and readable value of the addressed CSR.
  always_comb begin
    lo_sel  = '0;
    hi_sel  = '0;
    ev_sel  = '0;
    inh_sel = 1'b0;
    ovf_sel = 1'b0;
    r_val   = '0;
    for (int unsigned i = 0; i < N_CNT; i++) begin
      if (csr_addr_i == CNT_LO_BASE + 12'(i)) begin
        lo_sel[i] = 1'b1;
        r_val     = rd_lo[i];
      end
      if (csr_addr_i == CNT_HI_BASE + 12'(i)) begin
        hi_sel[i] = 1'b1;
        r_val     = rd_hi[i];
      end
      if (csr_addr_i == EVSEL_BASE + 12'(i)) begin
        ev_sel[i] = 1'b1;
        r_val     = {irq_en_q[i], sat_q[i], 22'b0, ev_idx_q[i]};
      end
    end
    if (csr_addr_i == INHIBIT_ADDR) begin
      inh_sel = 1'b1;
      r_val   = 32'(inhibit_q);
    end
    if (csr_addr_i == OVF_ADDR) begin
      ovf_sel = 1'b1;
      r_val   = 32'(ovf_q);
    end
  end

  assign any_hit     = (|lo_sel) | (|hi_sel) | (|ev_sel) | inh_sel | ovf_sel;
  assign csr_hit_o   = csr_access_i & any_hit;
  assign csr_rdata_o = csr_hit_o ? r_val : '0;
  assign we          = csr_hit_o & (csr_op_e'(csr_op_i) != CSR_NONE);
  assign new_val     = csr_apply(csr_op_e'(csr_op_i), r_val, csr_wdata_i);
  assign ovf_irq_o   = irq_q;

  // Per-counter increment request from the selected registered event.
  always_comb begin
    inc = '0;
    for (int unsigned i = 0; i < N_CNT; i++) begin
      inc[i] = evt_ext[ev_idx_q[i]] & ~inhibit_q[i] & ~freeze_i;
    end
  end

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    hpm_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (inc[g]),
      .sat_i   (sat_q[g]),
      .wr_lo_i (we & lo_sel[g]),
      .wr_hi_i (we & hi_sel[g]),
      .wdata_i (new_val),
      .rd_lo_o (rd_lo[g]),
      .rd_hi_o (rd_hi[g]),
      .ovf_o   (ovf_pulse[g])
    );
  end

  // Event capture stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) events_q <= '0;
    else        events_q <= events_i;
  end

  // Selector and inhibit configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CNT; i++) ev_idx_q[i] <= '0;
      sat_q     <= '0;
      irq_en_q  <= '0;
      inhibit_q <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        if (ev_sel[i]) begin
          ev_idx_q[i] <= new_val[EV_IDX_MSB:EV_IDX_LSB];
          sat_q[i]    <= new_val[SAT_BIT];
          irq_en_q[i] <= new_val[IRQ_EN_BIT];
        end
      end
      if (inh_sel) inhibit_q <= new_val[N_CNT-1:0];
    end
  end

  // Sticky overflow flags; a fresh overflow beats a coincident software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ((we & ovf_sel) ? new_val[N_CNT-1:0] : ovf_q) | ovf_pulse;
  end

  // Registered overflow interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |(ovf_q & irq_en_q);
  end

endmodule

// File: doc/hpm_counter_bank.md
Name: hpm_counter_bank

Overview:
Parametrised hardware performance-monitor bank for the core's CSR unit. It provides N_CNT programmable counters up to 64 bits wide, each with a selectable event source, and wrap or saturate mode. Each counter also has a sticky overflow flag that can raise an interrupt. The block attaches to the CSR access bus beside the machine-mode CSRs and supersedes the fixed-category counter scheme.

Parameters:
N_CNT, 4, number of counters (1..29)
CNT_W, 48, counter width in bits (1..64)
N_EVT, 16, number of event inputs (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset
csr_access_i  in  1  CSR access strobe; no read or write effect when low
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  write operand
csr_op_i  in  2  0 NONE, 1 WRITE, 2 SET, 3 CLEAR
csr_rdata_o  out  32  read data, combinational
csr_hit_o  out  1  address maps to this bank, combinational
events_i  in  N_EVT  per-cycle event pulses
freeze_i  in  1  debug halt; blocks all increments
ovf_irq_o  out  1  overflow interrupt, registered

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clk is the clock.
- Reset values:
  - counters, event selectors, inhibit, overflow flags, events_q: 0.
  - ovf_irq_o: 0.
  - Nothing counts until software programs a selector.
- Address map (i = 0..N_CNT-1):
  - 0xB03+i CNT_LO: counter bits [31:0].
  - 0xB83+i CNT_HI: counter bits [CNT_W-1:32], zero-extended.
  - 0x323+i EVSEL:
    - [7:0] event index; 0 = none, k selects events_i[k-1]; indices above N_EVT count nothing.
    - [30] SAT (1 saturate, 0 wrap).
    - [31] IRQ_EN.
    - Other bits read 0.
  - 0x320 INHIBIT: bit i=1 stops counter i.
  - 0x7C0 OVF: sticky overflow flag per counter.
- Unmapped addresses or csr_access_i=0: csr_hit_o=0, csr_rdata_o=0, no state change.
- CSR ops: let R be the current readable value.
  - WRITE: new = wdata.
  - SET: new = R | wdata.
  - CLEAR: new = R & ~wdata.
  - NONE: read only.
  - Unimplemented bits are discarded.
  - Updates take effect at the next edge.
- Field width rules:
  - CNT_LO write touches bits [31:0] only, and only bits below CNT_W; bits above are preserved.
  - CNT_HI write touches [CNT_W-1:32] only.
  - If CNT_W<=32, CNT_HI reads 0 and writes are ignored.
- Increment pipeline:
  - events_i is registered into events_q.
  - inc_i = selected events_q bit & ~inhibit[i] & ~freeze_i.
  - Counter updates at the following edge, so an event at cycle t is visible on read in cycle t+2.
  - Maximum one increment per cycle per counter.
- Overflow, on increment with counter = all-ones:
  - Wrap mode: counter becomes 0.
  - Saturate mode: counter holds all-ones.
  - Both modes set OVF[i].
  - OVF bits clear only by CSR write/clear.
- Interrupt: ovf_irq_o <= |(OVF & IRQ_EN vector), registered one cycle after OVF/IRQ_EN change. It stays high until software clears the flag or enable.
- Simultaneous events:
  - CSR write to a counter in the same cycle as an increment: the write wins, the increment is lost.
  - CSR write to OVF coinciding with a new overflow of counter i: OVF[i] ends set.
  - Writing INHIBIT or EVSEL affects increments from the next cycle (events_q already captured uses new config at the update edge).
- Reset mid-operation: all state returns to reset values immediately; no partial increments survive.

Decomposition:
- Shared package hpm_pkg:
  - csr_op_e enum.
  - Address constants CNT_LO_BASE, CNT_HI_BASE, EVSEL_BASE, INHIBIT_ADDR, OVF_ADDR.
  - EVSEL field positions (EV_IDX, SAT, IRQ_EN).
- Sub-module hpm_counter, instantiated N_CNT times. One slice holds the CNT_W register and the increment, wrap/saturate, lo/hi write merge and overflow-pulse output.
- Top level holds address decode, read mux, event registers, selector muxes, INHIBIT/OVF and irq flop.

Test Plan:
- Reset, then read every mapped CSR -> all 0, ovf_irq_o=0; read 0x123 -> csr_hit_o=0, rdata 0.
- Program EVSEL0=0x01, pulse events_i[0] for 5 cycles -> CNT_LO0=5, first increment visible 2 cycles after first pulse.
- CNT_W=48: write CNT_HI0=0xFFFF, CNT_LO0=0xFFFFFFFF, EVSEL0=0x80000001, one event -> counter wraps to 0, OVF=0x1, ovf_irq_o=1 next cycle; CLEAR OVF with 0x1 -> irq drops.
- Same setup with SAT=1 and 3 events -> counter stays 0xFFFF_FFFFFFFF, OVF[0]=1.
- Event active every cycle, then WRITE CNT_LO0=0x100 -> next read 0x100, with the increment that coincided with the write dropped; then freeze_i=1 or INHIBIT=0x1 -> count holds.
- Apply the SET, CLEAR and NONE ops to EVSEL1 = 0x5 -> each yields the correct R|w / R&~w value; NONE leaves it unchanged.
